ysyx_25060170_wbu: RTL

//  Write-back unit: the consumer end of the EXU result interface (result, rd, valid/ready).

---
 rtl/ysyx_25060170_wbu.sv | 102 ++++++++++
 1 files changed

// File: rtl/ysyx_25060170_wbu.sv
// Write-back unit: single-entry stage between the EXU result interface and the register-file
// write port, with a retired-instruction counter and a sticky halt on ebreak retirement.
module ysyx_25060170_wbu #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [DATA_W-1:0] ex_result_i,
    input  logic [4:0]        ex_rd_i,
    input  logic              ex_halt_i,
    output logic              rf_req_o,
    input  logic              rf_gnt_i,
    output logic              rf_wen_o,
    output logic [4:0]        rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              retire_o,
    output logic [CNT_W-1:0]  instret_o,
    output logic              halted_o
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              stageValid_q, stageValid_d;
    logic [DATA_W-1:0] stageResult_q, stageResult_d;
    logic [4:0]        stageRd_q, stageRd_d;
    logic              stageHalt_q, stageHalt_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    logic running;
    logic needWr;
    logic retire;
    logic exReady;
    logic handshake;

    // Every output is forced low while reset is held, so gate the run condition with rst.
    always_comb begin
        running   = (state_q == RUN) && !rst;
        needWr    = stageValid_q && (stageRd_q != 5'd0) && !stageHalt_q;
        retire    = running && stageValid_q && (rf_gnt_i || !needWr);
        exReady   = running && (!stageValid_q || (retire && !stageHalt_q));
        handshake = ex_valid_i && exReady;
    end

    always_comb begin
        ex_ready_o = exReady;
        rf_req_o   = running && needWr;
        rf_wen_o   = running && needWr && rf_gnt_i;
        retire_o   = retire;
        rf_waddr_o = (stageValid_q && !rst) ? stageRd_q : 5'd0;
        rf_wdata_o = (stageValid_q && !rst) ? stageResult_q : '0;
        instret_o  = rst ? '0 : instret_q;
        halted_o   = (state_q == HALT) && !rst;
    end

    // A new capture overrides the retire-clear so the stage sustains one entry per cycle.
    always_comb begin
        state_d       = state_q;
        stageValid_d  = stageValid_q;
        stageResult_d = stageResult_q;
        stageRd_d     = stageRd_q;
        stageHalt_d   = stageHalt_q;
        instret_d     = instret_q;
        if (retire) begin
            instret_d = instret_q + 1'b1;
            if (stageHalt_q) begin
                state_d = HALT;
            end
        end
        if (handshake) begin
            stageValid_d  = 1'b1;
            stageResult_d = ex_result_i;
            stageRd_d     = ex_rd_i;
            stageHalt_d   = ex_halt_i;
        end else if (retire) begin
            stageValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            stageValid_q  <= 1'b0;
            stageResult_q <= '0;
            stageRd_q     <= 5'd0;
            stageHalt_q   <= 1'b0;
            instret_q     <= '0;
        end else begin
            state_q       <= state_d;
            stageValid_q  <= stageValid_d;
            stageResult_q <= stageResult_d;
            stageRd_q     <= stageRd_d;
            stageHalt_q   <= stageHalt_d;
            instret_q     <= instret_d;
        end
    end

endmodule
